// File: rtl/video_pixel_feeder_pkg.sv
// Shared definitions for the pixel feeder: FSM state encoding, pixel width,
// error colour and the saturating counter helper.
package video_pixel_feeder_pkg;

    typedef enum logic [1:0] {
        WAIT_FILL = 2'd0,
        STREAM    = 2'd1,
        UNDERFLOW = 2'd2
    } feeder_state_t;

    localparam int              RGB_W   = 24;
    localparam logic [RGB_W-1:0] ERR_RGB = 24'hFF00FF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/video_pixel_feeder_if.sv
// Read side of the show-ahead pixel FIFO. The feeder is the master: it
// decides when to pop; the FIFO presents head word, empty flag and fill level.
interface video_pixel_feeder_if
    import video_pixel_feeder_pkg::*;
#(
    parameter int LEVEL_W = 10
);
    logic [RGB_W-1:0]   fifo_rdata;
    logic               fifo_empty;
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_rinc;

    modport master (
        output fifo_rinc,
        input  fifo_rdata,
        input  fifo_empty,
        input  fifo_level
    );

    modport slave (
        input  fifo_rinc,
        output fifo_rdata,
        output fifo_empty,
        output fifo_level
    );
endinterface

// File: rtl/video_pixel_feeder.sv
// Pixel-clock stage in front of the video output: pops pixels from the FIFO
// during active display, delays sync/enable by one cycle to match the
// registered pixel, and drops into an error-colour state on FIFO underflow or
// a short frame until the next frame boundary with enough fill.
module video_pixel_feeder
    import video_pixel_feeder_pkg::*;
#(
    parameter int          HDISP       = 800,
    parameter int          VDISP       = 480,
    parameter int          LEVEL_W     = 10,
    parameter int          START_LEVEL = 256,
    parameter logic [15:0] UCNT_RST    = 16'h0000
) (
    input  logic                 pixel_clk,
    input  logic                 pixel_rst_n,
    input  logic                 hs_i,
    input  logic                 vs_i,
    input  logic                 de_i,
    video_pixel_feeder_if.master fifo,
    output logic                 hs_o,
    output logic                 vs_o,
    output logic                 de_o,
    output logic [RGB_W-1:0]     rgb_o,
    output logic                 flush_req,
    output logic [15:0]          underflow_cnt
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [XW-1:0]      X_LAST    = XW'(HDISP - 1);
    localparam logic [YW-1:0]      Y_LAST    = YW'(VDISP - 1);
    localparam logic [LEVEL_W-1:0] LVL_START = LEVEL_W'(START_LEVEL);

    feeder_state_t    state_q, state_d;
    logic             vs_prev_q;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             hs_q, vs_q, de_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             flush_q, flush_d;
    logic [15:0]      ucnt_q, ucnt_d;

    logic frame_start;
    logic level_ok;

    // Frame boundary is the falling edge of vs_i; it wins over de_i.
    assign frame_start = vs_prev_q & ~vs_i;
    assign level_ok    = (fifo.fifo_level >= LVL_START);

    // Pop only on a visible pixel in STREAM with a valid head word.
    assign fifo.fifo_rinc = (state_q == STREAM) & de_i & ~fifo.fifo_empty & ~frame_start;

    // Next-state, position counters, underflow accounting and pixel select.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        flush_d = flush_q;
        ucnt_d  = ucnt_q;
        rgb_d   = '0;
        if (frame_start) begin
            x_d = '0;
            y_d = '0;
            unique case (state_q)
                WAIT_FILL: begin
                    if (level_ok) begin
                        state_d = STREAM;
                        flush_d = 1'b0;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
                STREAM: begin
                    // Frame ended early: upstream lost sync with the display.
                    if ((x_q != '0) || (y_q != '0)) begin
                        state_d = UNDERFLOW;
                        flush_d = 1'b1;
                        ucnt_d  = sat_inc16(ucnt_q);
                    end
                end
                UNDERFLOW: begin
                    state_d = WAIT_FILL;
                    flush_d = ~level_ok;
                end
                default: state_d = WAIT_FILL;
            endcase
        end else begin
            if (de_i) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            unique case (state_q)
                WAIT_FILL: flush_d = ~level_ok;
                STREAM: begin
                    if (de_i) begin
                        if (fifo.fifo_empty) begin
                            state_d = UNDERFLOW;
                            flush_d = 1'b1;
                            ucnt_d  = sat_inc16(ucnt_q);
                            rgb_d   = ERR_RGB;
                        end else begin
                            rgb_d = fifo.fifo_rdata;
                        end
                    end
                end
                UNDERFLOW: begin
                    flush_d = 1'b1;
                    if (de_i) begin
                        rgb_d = ERR_RGB;
                    end
                end
                default: state_d = WAIT_FILL;
            endcase
        end
    end

    // State and output registers; sync/enable delayed one cycle with the pixel.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q   <= WAIT_FILL;
            vs_prev_q <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            de_q      <= 1'b0;
            rgb_q     <= '0;
            flush_q   <= 1'b1;
            ucnt_q    <= UCNT_RST;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= vs_i;
            x_q       <= x_d;
            y_q       <= y_d;
            hs_q      <= hs_i;
            vs_q      <= vs_i;
            de_q      <= de_i;
            rgb_q     <= rgb_d;
            flush_q   <= flush_d;
            ucnt_q    <= ucnt_d;
        end
    end

    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign de_o          = de_q;
    assign rgb_o         = rgb_q;
    assign flush_req     = flush_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_video_pixel_feeder.sv
// Directed bench for video_pixel_feeder on a reduced 8x4 raster. A second
// instance with a near-full underflow counter reset value exercises saturation.
module tb_video_pixel_feeder;
    import video_pixel_feeder_pkg::*;

    localparam int H = 8;
    localparam int V = 4;
    localparam int M_WAIT   = 0;
    localparam int M_STREAM = 1;
    localparam int M_UFL    = 2;
    localparam int TIMEOUT_CYC = 20000;

    logic pixel_clk = 1'b0;
    logic pixel_rst_n = 1'b1;
    logic hs_i = 1'b1, vs_i = 1'b1, de_i = 1'b0;

    logic hs_o, vs_o, de_o, flush_req;
    logic [23:0] rgb_o;
    logic [15:0] underflow_cnt;
    logic hs_o2, vs_o2, de_o2, flush_req2;
    logic [23:0] rgb_o2;
    logic [15:0] underflow_cnt2;

    int tests = 0;
    int fails = 0;
    int head = 0;
    int exp_idx = 0;
    int frame_no = 0;
    bit done = 1'b0;

    video_pixel_feeder_if #(.LEVEL_W(10)) fif ();
    video_pixel_feeder_if #(.LEVEL_W(10)) fif2 ();

    function automatic logic [23:0] pix(input int i);
        logic [31:0] v;
        v = i * 32'h0001_0307 + 32'h0012_3456;
        return v[23:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Show-ahead FIFO model: head word advances on every pop.
    assign fif.fifo_rdata = pix(head);
    always @(posedge pixel_clk) begin
        if (fif.fifo_rinc === 1'b1) head <= head + 1;
    end

    assign fif2.fifo_rdata = fif.fifo_rdata;
    assign fif2.fifo_empty = fif.fifo_empty;
    assign fif2.fifo_level = fif.fifo_level;

    always #5 pixel_clk = ~pixel_clk;

    video_pixel_feeder #(.HDISP(H), .VDISP(V), .LEVEL_W(10), .START_LEVEL(256)) dut (
        .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
        .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i), .fifo(fif.master),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o),
        .flush_req(flush_req), .underflow_cnt(underflow_cnt)
    );

    video_pixel_feeder #(.HDISP(H), .VDISP(V), .LEVEL_W(10), .START_LEVEL(256),
                         .UCNT_RST(16'hFFFE)) dut_sat (
        .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
        .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i), .fifo(fif2.master),
        .hs_o(hs_o2), .vs_o(vs_o2), .de_o(de_o2), .rgb_o(rgb_o2),
        .flush_req(flush_req2), .underflow_cnt(underflow_cnt2)
    );

    // Watchdog: the run must finish within a bounded number of cycles.
    initial begin
        repeat (TIMEOUT_CYC) @(posedge pixel_clk);
        if (!done) begin
            fails++;
            $error("FAIL timeout: bench did not finish within %0d cycles", TIMEOUT_CYC);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // One pixel clock: entered and left at posedge+1.
    task automatic cyc(input logic hs, input logic vs, input logic de, input logic emp,
                       input logic exp_rinc, input logic [23:0] exp_rgb);
        hs_i = hs;
        vs_i = vs;
        de_i = de;
        fif.fifo_empty = emp;
        #1;
        chk("rinc", fif.fifo_rinc, exp_rinc);
        @(posedge pixel_clk);
        #1;
        chk("outs", {hs_o, vs_o, de_o, rgb_o}, {hs, vs, de, exp_rgb});
    endtask

    // One frame: vs pulse, then `lines` lines of H visible pixels.
    task automatic frame(input int lines, input int mode, input int lvl_s, input int lvl_m,
                         input int eline, input int epix);
        bit dead;
        dead = (mode == M_UFL);
        fif.fifo_level = 10'(lvl_s);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        fif.fifo_level = 10'(lvl_m);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        for (int l = 0; l < lines; l++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
            for (int p = 0; p < H; p++) begin
                if (mode == M_STREAM && !dead) begin
                    if (l == eline && p == epix) begin
                        dead = 1'b1;
                        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ERR_RGB);
                    end else begin
                        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, pix(exp_idx));
                        exp_idx++;
                    end
                end else if (dead) begin
                    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ERR_RGB);
                end else begin
                    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
                end
            end
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        end
        $display("[TB] frame %0d mode %0d lines %0d pops %0d ucnt %0h flush %0b",
                 frame_no, mode, lines, head, underflow_cnt, flush_req);
        frame_no++;
    endtask

    initial begin
        fif.fifo_empty = 1'b0;
        fif.fifo_level = 10'd300;

        // Reset state
        #2 pixel_rst_n = 1'b0;
        #1;
        chk("rst_hs", hs_o, 1'b1);
        chk("rst_vs", vs_o, 1'b1);
        chk("rst_de", de_o, 1'b0);
        chk("rst_rgb", rgb_o, 24'h0);
        chk("rst_flush", flush_req, 1'b1);
        chk("rst_ucnt", underflow_cnt, 16'h0);
        chk("rst_ucnt_sat", underflow_cnt2, 16'hFFFE);
        repeat (3) @(posedge pixel_clk);
        #1 pixel_rst_n = 1'b1;

        // Fill level already above threshold: flush drops before any frame
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("fill_flush", flush_req, 1'b0);

        // Two full frames streaming, counters wrap cleanly
        frame(V, M_STREAM, 300, 300, -1, -1);
        chk("f0_pops", head, 32);
        chk("f0_ucnt", underflow_cnt, 16'h0);
        chk("f0_flush", flush_req, 1'b0);
        frame(V, M_STREAM, 300, 300, -1, -1);
        chk("f1_pops", head, 64);
        chk("f1_ucnt", underflow_cnt, 16'h0);

        // FIFO empty at line 2 pixel 5: error colour for rest of frame
        frame(V, M_STREAM, 300, 300, 2, 5);
        chk("f2_pops", head, 64 + 21);
        chk("f2_ucnt", underflow_cnt, 16'h1);
        chk("f2_flush", flush_req, 1'b1);
        chk("f2_ucnt_sat", underflow_cnt2, 16'hFFFF);

        // Low fill: waits; level rises mid-frame; streaming only at next frame
        frame(V, M_WAIT, 100, 100, -1, -1);
        chk("f3_flush", flush_req, 1'b1);
        chk("f3_pops", head, 85);
        frame(V, M_WAIT, 100, 300, -1, -1);
        chk("f4_flush", flush_req, 1'b0);
        chk("f4_pops", head, 85);
        frame(V, M_STREAM, 300, 300, -1, -1);
        chk("f5_pops", head, 117);
        chk("f5_ucnt", underflow_cnt, 16'h1);

        // Short frame: vs falls after 2 of 4 lines
        frame(2, M_STREAM, 300, 300, -1, -1);
        chk("f6_ucnt", underflow_cnt, 16'h1);
        chk("f6_pops", head, 133);
        frame(V, M_UFL, 300, 300, -1, -1);
        chk("f7_ucnt", underflow_cnt, 16'h2);
        chk("f7_flush", flush_req, 1'b1);
        chk("f7_pops", head, 133);
        chk("f7_ucnt_sat", underflow_cnt2, 16'hFFFF);
        frame(V, M_WAIT, 300, 300, -1, -1);
        chk("f8_flush", flush_req, 1'b0);
        frame(V, M_STREAM, 300, 300, -1, -1);
        chk("f9_pops", head, 165);
        chk("pop_model", head, exp_idx);

        // Reset asserted mid-line while popping
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, pix(exp_idx));
        exp_idx++;
        de_i = 1'b1;
        #1;
        chk("pre_rst_rinc", fif.fifo_rinc, 1'b1);
        #1 pixel_rst_n = 1'b0;
        #1;
        chk("mid_rst_rinc", fif.fifo_rinc, 1'b0);
        chk("mid_rst_outs", {hs_o, vs_o, de_o, rgb_o}, {1'b1, 1'b1, 1'b0, 24'h0});
        chk("mid_rst_flush", flush_req, 1'b1);
        chk("mid_rst_ucnt", underflow_cnt, 16'h0);
        chk("mid_rst_ucnt_sat", underflow_cnt2, 16'hFFFE);
        de_i = 1'b0;
        repeat (2) @(posedge pixel_clk);
        #1 pixel_rst_n = 1'b1;
        chk("post_rst_pops", head, exp_idx);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("post_rst_flush", flush_req, 1'b0);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
